// File: rtl/rd_sched_if.sv
// rd_sched_if: scheduler-side bundle carrying the fill pulses, bank locks,
// the bank-memory read port and the valid/ready output stream.
interface rd_sched_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          mem0_fill_done;
  logic          mem1_fill_done;
  logic          mem0_lock;
  logic          mem1_lock;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          err_ovf;

  modport master (
    input  mem0_fill_done, mem1_fill_done, rd_data, out_ready,
    output mem0_lock, mem1_lock, rd_en, rd_bank, rd_addr, out_valid, out_data, err_ovf
  );

  modport slave (
    output mem0_fill_done, mem1_fill_done, rd_data, out_ready,
    input  mem0_lock, mem1_lock, rd_en, rd_bank, rd_addr, out_valid, out_data, err_ovf
  );
endinterface

// File: rtl/rd_sched.sv
// rd_sched: drains filled reorder-FIFO banks in fill order into a 2-entry skid buffer.
// Define RD_SCHED_STATS_EN to add the drain_cnt output (fully drained banks).
module rd_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef RD_SCHED_STATS_EN
  output logic [15:0] drain_cnt,
`endif
  rd_sched_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RD0, RD1} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [1:0]    q_bank_q, q_bank_n;
  logic [1:0]    q_cnt_q, q_cnt_n;
  logic          lock0_q, lock1_q, err_q;
  logic          push0, push1, pop, rd_en, last_issue;
  logic [2:0]    v;
  logic [2:0]    vn;
  logic          inflight_q;
  logic [DW-1:0] sk_data [2];
  logic [1:0]    sk_cnt;
  logic          out_valid, out_pop, sk_push, sk_pop;
  logic [DW-1:0] out_data;

  assign push0      = bus.mem0_fill_done && !lock0_q;
  assign push1      = bus.mem1_fill_done && !lock1_q;
  assign rd_en      = (state_q != IDLE) && (({1'b0, sk_cnt} + {2'b00, inflight_q}) < 3'd2);
  assign last_issue = rd_en && (addr_q == LAST_ADDR);

  // Queued bank ids followed by this cycle's pushes, so a fresh fill can start a drain at once.
  always_comb begin
    v  = {1'b0, q_bank_q};
    vn = {1'b0, q_cnt_q};
    if (push0) begin
      v[vn[1:0]] = 1'b0;
      vn         = vn + 3'd1;
    end
    if (push1) begin
      v[vn[1:0]] = 1'b1;
      vn         = vn + 3'd1;
    end
  end

  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    q_bank_n = v[1:0];
    q_cnt_n  = vn[1:0];
    pop      = 1'b0;
    case (state_q)
      IDLE: pop = (vn != 3'd0);
      default: begin
        if (rd_en) begin
          if (addr_q == LAST_ADDR) begin
            addr_n  = '0;
            state_n = IDLE;
            pop     = (vn != 3'd0);
          end else begin
            addr_n = addr_q + AW'(1);
          end
        end
      end
    endcase
    if (pop) begin
      state_n  = v[0] ? RD1 : RD0;
      addr_n   = '0;
      q_bank_n = v[2:1];
      q_cnt_n  = vn[1:0] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      q_bank_q <= '0;
      q_cnt_q  <= '0;
      lock0_q  <= 1'b0;
      lock1_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      q_bank_q <= q_bank_n;
      q_cnt_q  <= q_cnt_n;
      if (push0)
        lock0_q <= 1'b1;
      else if (last_issue && state_q == RD0)
        lock0_q <= 1'b0;
      if (push1)
        lock1_q <= 1'b1;
      else if (last_issue && state_q == RD1)
        lock1_q <= 1'b0;
      if ((bus.mem0_fill_done && lock0_q) || (bus.mem1_fill_done && lock1_q))
        err_q <= 1'b1;
    end
  end

  // Returning read data bypasses the buffer when it is empty and accepted immediately.
  assign out_valid = (sk_cnt != 2'd0) || inflight_q;
  assign out_pop   = out_valid && bus.out_ready;
  assign sk_pop    = out_pop && (sk_cnt != 2'd0);
  assign sk_push   = inflight_q && !(out_pop && sk_cnt == 2'd0);

  always_comb begin
    out_data = '0;
    if (sk_cnt != 2'd0)
      out_data = sk_data[0];
    else if (inflight_q)
      out_data = bus.rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      sk_cnt     <= '0;
      sk_data[0] <= '0;
      sk_data[1] <= '0;
    end else begin
      inflight_q <= rd_en;
      if (sk_pop && sk_push) begin
        if (sk_cnt == 2'd1) begin
          sk_data[0] <= bus.rd_data;
        end else begin
          sk_data[0] <= sk_data[1];
          sk_data[1] <= bus.rd_data;
        end
      end else if (sk_pop) begin
        sk_data[0] <= sk_data[1];
        sk_cnt     <= sk_cnt - 2'd1;
      end else if (sk_push) begin
        sk_data[sk_cnt[0]] <= bus.rd_data;
        sk_cnt             <= sk_cnt + 2'd1;
      end
    end
  end

`ifdef RD_SCHED_STATS_EN
  // Banks leave the buffer whole and in order, so every DEPTH-th pop ends a bank.
  logic [AW-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      drain_cnt  <= '0;
    end else if (out_pop) begin
      beat_cnt_q <= beat_cnt_q + AW'(1);
      if (beat_cnt_q == LAST_ADDR)
        drain_cnt <= drain_cnt + 16'd1;
    end
  end
`endif

  assign bus.mem0_lock = lock0_q;
  assign bus.mem1_lock = lock1_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_bank   = (state_q == RD1);
  assign bus.rd_addr   = addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.err_ovf   = err_q;

endmodule

// File: tb/tb_rd_sched.sv
// tb_rd_sched: bank-memory model, scoreboard of expected beats, table-driven
// fill scenarios plus hand-timed sequences for latency, bank switch and reset.
module tb_rd_sched;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NVEC  = 7;

  typedef struct {
    int f0_at;
    int f0b_at;
    int f1_at;
    bit toggle;
    int exp_beats;
    bit exp_err;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sb [$];
  logic [1:0]    pending;
  int            beats, issued, popped, max_out;
  bit            ready_toggle = 1'b0;
  bit            stalled_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] exp_word;
  vec_t          vecs [NVEC];

  rd_sched_if #(.DW(DW), .AW(AW)) bus ();

`ifdef RD_SCHED_STATS_EN
  logic [15:0] drain_cnt;
`endif

  rd_sched #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RD_SCHED_STATS_EN
    .drain_cnt(drain_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic b, input logic [AW-1:0] a);
    return {16'hC0DE, 7'h00, b, 4'h0, a};
  endfunction

  // Bank memory with one cycle of read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.rd_data <= '0;
    else if (bus.rd_en)
      bus.rd_data <= pat(bus.rd_bank, bus.rd_addr);
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_toggle ? ~bus.out_ready : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability and outstanding-read tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (bus.rd_en) issued++;
      if (issued - popped > max_out) max_out = issued - popped;
      if (stalled_prev) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_stable", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        popped++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL extra_beat: got 0x%0h, expected no beat", bus.out_data);
        end else begin
          exp_word = sb.pop_front();
          checkOutput("beat_data", bus.out_data, exp_word);
          beats++;
          if (exp_word[3:0] == 4'hF) pending[exp_word[8]] = 1'b0;
        end
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_data    = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    pending = '0;
    beats   = 0;
    issued  = 0;
    popped  = 0;
    max_out = 0;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.mem0_fill_done = 1'b0;
    bus.mem1_fill_done = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // A fill for a bank still pending is refused by the scheduler, so nothing is expected.
  task automatic push_bank(input logic b);
    if (!pending[b]) begin
      for (int i = 0; i < DEPTH; i++) sb.push_back(pat(b, AW'(i)));
      pending[b] = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.timeout: got %0d beats left, expected 0", name, sb.size());
    end
    repeat (3) step();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int    last;
    string nm;
    nm = $sformatf("vec%0d", idx);
    do_reset();
    ready_toggle = v.toggle;
    last = v.f0_at;
    if (v.f0b_at > last) last = v.f0b_at;
    if (v.f1_at > last) last = v.f1_at;
    for (int c = 0; c <= last; c++) begin
      bus.mem0_fill_done = (c == v.f0_at) || (c == v.f0b_at);
      bus.mem1_fill_done = (c == v.f1_at);
      if (bus.mem0_fill_done) push_bank(1'b0);
      if (bus.mem1_fill_done) push_bank(1'b1);
      step();
    end
    bus.mem0_fill_done = 1'b0;
    bus.mem1_fill_done = 1'b0;
    wait_drain(nm);
    ready_toggle = 1'b0;
    @(negedge clk);
    checkOutput({nm, ".beats"}, 32'(beats), 32'(v.exp_beats));
    checkOutput({nm, ".err_ovf"}, 32'(bus.err_ovf), 32'(v.exp_err));
    checkOutput({nm, ".lock0"}, 32'(bus.mem0_lock), 32'd0);
    checkOutput({nm, ".lock1"}, 32'(bus.mem1_lock), 32'd0);
    checkOutput({nm, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({nm, ".outstanding_le2"}, 32'(max_out <= 2), 32'd1);
  endtask

  initial begin
    int rd_cycles, ov_cycles, n;
    bus.mem0_fill_done = 1'b0;
    bus.mem1_fill_done = 1'b0;
    clear_model();

    vecs[0] = '{0, -1, -1, 1'b0, 16, 1'b0};
    vecs[1] = '{0, -1,  2, 1'b0, 32, 1'b0};
    vecs[2] = '{0, -1, -1, 1'b1, 16, 1'b0};
    vecs[3] = '{0,  3, -1, 1'b0, 16, 1'b1};
    vecs[4] = '{0, -1,  0, 1'b0, 32, 1'b0};
    vecs[5] = '{-1, -1, 0, 1'b1, 16, 1'b0};
    vecs[6] = '{4, -1,  0, 1'b1, 32, 1'b0};

    #12;
    checkOutput("reset.lock0", 32'(bus.mem0_lock), 32'd0);
    checkOutput("reset.lock1", 32'(bus.mem1_lock), 32'd0);
    checkOutput("reset.rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.out_data", bus.out_data, 32'd0);
    checkOutput("reset.err_ovf", 32'(bus.err_ovf), 32'd0);

    // Bank0 then bank1 two cycles later: exact latency, seamless switch, lock release.
    do_reset();
    rd_cycles = 0;
    ov_cycles = 0;
    bus.mem0_fill_done = 1'b1;
    push_bank(1'b0);
    step();
    bus.mem0_fill_done = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      bus.mem1_fill_done = (c == 2);
      if (c == 2) push_bank(1'b1);
      @(negedge clk);
      if (bus.rd_en) rd_cycles++;
      if (bus.out_valid) ov_cycles++;
      case (c)
        1: begin
          checkOutput("seq.c1_lock0", 32'(bus.mem0_lock), 32'd1);
          checkOutput("seq.c1_rd_en", 32'(bus.rd_en), 32'd1);
          checkOutput("seq.c1_addr", 32'(bus.rd_addr), 32'd0);
          checkOutput("seq.c1_valid", 32'(bus.out_valid), 32'd0);
        end
        2: begin
          checkOutput("seq.c2_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("seq.c2_data", bus.out_data, pat(1'b0, 4'd0));
        end
        16: begin
          checkOutput("seq.c16_addr", 32'(bus.rd_addr), 32'd15);
          checkOutput("seq.c16_lock0", 32'(bus.mem0_lock), 32'd1);
        end
        17: begin
          checkOutput("seq.c17_rd_en", 32'(bus.rd_en), 32'd1);
          checkOutput("seq.c17_bank", 32'(bus.rd_bank), 32'd1);
          checkOutput("seq.c17_addr", 32'(bus.rd_addr), 32'd0);
          checkOutput("seq.c17_lock0", 32'(bus.mem0_lock), 32'd0);
        end
        32: checkOutput("seq.c32_lock1", 32'(bus.mem1_lock), 32'd1);
        33: begin
          checkOutput("seq.c33_lock1", 32'(bus.mem1_lock), 32'd0);
          checkOutput("seq.c33_data", bus.out_data, pat(1'b1, 4'd15));
        end
        34: checkOutput("seq.c34_valid", 32'(bus.out_valid), 32'd0);
        default: ;
      endcase
      step();
    end
    bus.mem1_fill_done = 1'b0;
    checkOutput("seq.rd_cycles", 32'(rd_cycles), 32'd32);
    checkOutput("seq.valid_cycles", 32'(ov_cycles), 32'd32);
    checkOutput("seq.beats", 32'(beats), 32'd32);
`ifdef RD_SCHED_STATS_EN
    checkOutput("seq.drain_cnt", 32'(drain_cnt), 32'd2);
`endif

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of a drain, then a clean drain of bank1.
    do_reset();
    bus.mem0_fill_done = 1'b1;
    push_bank(1'b0);
    step();
    bus.mem0_fill_done = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rd_en && bus.rd_addr == 4'd7) && n < 50);
    checkOutput("rst.reach_addr7", 32'(bus.rd_addr), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.lock0", 32'(bus.mem0_lock), 32'd0);
    checkOutput("rst.rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("rst.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst.out_data", bus.out_data, 32'd0);
    checkOutput("rst.rd_addr", 32'(bus.rd_addr), 32'd0);
    clear_model();
    step();
    step();
    rst_n = 1'b1;
    bus.mem1_fill_done = 1'b1;
    push_bank(1'b1);
    step();
    bus.mem1_fill_done = 1'b0;
    wait_drain("rst");
    @(negedge clk);
    checkOutput("rst.beats", 32'(beats), 32'd16);
    checkOutput("rst.lock1", 32'(bus.mem1_lock), 32'd0);
    checkOutput("rst.err_ovf", 32'(bus.err_ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
